// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX->MEM bus, waits on SRAM load data, aligns it and drives the WB/forwarding buses.
// Define MEM_ALIGN_CHECK_EN to add the mem_adel misaligned-load flag.
module mem_stage #(
    parameter int EX_TO_MEM_WD = 146,
    parameter int MEM_TO_WB_WD = 136,
    parameter int STALL_WD     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_WD-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    input  logic                    data_sram_data_ok,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_WB_WD-1:0] mem_to_id_bus,
`ifdef MEM_ALIGN_CHECK_EN
    output logic                    mem_adel,
`endif
    output logic                    stallreq_for_mem
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    state_t                  state, next_state;
    logic [EX_TO_MEM_WD-1:0] r;
    logic [31:0]             load_buf;
    logic                    buf_capture;

    logic [31:0] pc, ex_result, hi_wdata, lo_wdata;
    logic        data_ram_en, sel_rf_res, rf_we, hi_we, lo_we;
    logic [4:0]  rf_waddr;
    logic [3:0]  ld_type;
    logic        load_type_ok, is_load, addr_err, load_go, flush;
    logic [31:0] ld_word, load_data, rf_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        unused_bits;

    // Stalled EX with a running MEM injects a bubble; a stalled MEM holds.
    assign flush = stall[3] & ~stall[4];

    always_ff @(posedge clk) begin
        if (rst)
            r <= '0;
        else if (flush)
            r <= '0;
        else if (!stall[3])
            r <= ex_to_mem_bus;
    end

    assign pc          = r[145:114];
    assign data_ram_en = r[113];
    assign sel_rf_res  = r[108];
    assign rf_we       = r[107];
    assign rf_waddr    = r[106:102];
    assign ex_result   = r[101:70];
    assign hi_we       = r[69];
    assign lo_we       = r[68];
    assign hi_wdata    = r[67:36];
    assign lo_wdata    = r[35:4];
    assign ld_type     = r[3:0];

    assign unused_bits = ^{r[112:109], stall[2:0], stall[STALL_WD-1:5]};

    always_comb begin
        load_type_ok = 1'b0;
        case (ld_type)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0110: load_type_ok = 1'b1;
            default:                                     load_type_ok = 1'b0;
        endcase
    end

    assign is_load = data_ram_en & load_type_ok;

`ifdef MEM_ALIGN_CHECK_EN
    assign addr_err = is_load & (((ld_type == 4'b0000) & (ex_result[1:0] != 2'b00)) |
                                 (((ld_type == 4'b0100) | (ld_type == 4'b0110)) & ex_result[0]));
    assign mem_adel = addr_err;
`else
    assign addr_err = 1'b0;
`endif

    // A faulting load never waits on the SRAM.
    assign load_go = is_load & ~addr_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            load_buf <= '0;
        end else begin
            state <= next_state;
            if (buf_capture)
                load_buf <= data_sram_rdata;
        end
    end

    always_comb begin
        next_state  = state;
        buf_capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (load_go && !data_sram_data_ok)
                    next_state = S_WAIT;
                else if (load_go && data_sram_data_ok && stall[3]) begin
                    next_state  = S_HOLD;
                    buf_capture = 1'b1;
                end
            end
            S_WAIT: begin
                if (data_sram_data_ok && stall[3]) begin
                    next_state  = S_HOLD;
                    buf_capture = 1'b1;
                end else if (data_sram_data_ok)
                    next_state = S_IDLE;
            end
            S_HOLD: begin
                if (!stall[3])
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        // The bubble discards whatever load was in flight.
        if (flush) begin
            next_state  = S_IDLE;
            buf_capture = 1'b0;
        end
    end

    always_comb begin
        ld_word = 32'h0;
        if (data_sram_data_ok)
            ld_word = data_sram_rdata;
        else if (state == S_HOLD)
            ld_word = load_buf;
        stallreq_for_mem = ~rst & load_go & ~data_sram_data_ok & (state != S_HOLD);
    end

    always_comb begin
        case (ex_result[1:0])
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = ex_result[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_type)
            4'b0001: load_data = {{24{ld_byte[7]}}, ld_byte};
            4'b0010: load_data = {24'h0, ld_byte};
            4'b0100: load_data = {{16{ld_half[15]}}, ld_half};
            4'b0110: load_data = {16'h0, ld_half};
            default: load_data = ld_word;
        endcase
        rf_wdata = sel_rf_res ? load_data : ex_result;
    end

    assign mem_to_wb_bus = {pc, rf_we & ~addr_err, rf_waddr, rf_wdata,
                            hi_we, lo_we, hi_wdata, lo_wdata};
    assign mem_to_id_bus = mem_to_wb_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for load alignment plus hand sequences for wait, hold, bubble and reset.
// Define MEM_ALIGN_CHECK_EN to also exercise the mem_adel flag.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [145:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic         data_sram_data_ok;
    logic [135:0] mem_to_wb_bus;
    logic [135:0] mem_to_id_bus;
    logic         stallreq_for_mem;
`ifdef MEM_ALIGN_CHECK_EN
    logic         mem_adel;
`endif

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] LW = 4'b0000, LB = 4'b0001, LBU = 4'b0010,
                           LH = 4'b0100, LHU = 4'b0110, SW = 4'b1111;
    localparam logic [5:0] ST_NONE = 6'b000000, ST_HOLD = 6'b011111, ST_BUBBLE = 6'b001111;

    typedef struct {
        logic [3:0]  ld_type;
        logic        en;
        logic        sel;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        ok;
        logic [31:0] exp_wdata;
        logic        exp_req;
    } vec_t;

    vec_t vecs[$];

    mem_stage dut (
        .clk               (clk),
        .rst               (rst),
        .stall             (stall),
        .ex_to_mem_bus     (ex_to_mem_bus),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .mem_to_wb_bus     (mem_to_wb_bus),
        .mem_to_id_bus     (mem_to_id_bus),
`ifdef MEM_ALIGN_CHECK_EN
        .mem_adel          (mem_adel),
`endif
        .stallreq_for_mem  (stallreq_for_mem)
    );

    always #5 clk = ~clk;

    function automatic logic [145:0] make_ex(input logic [31:0] pc, input logic en, input logic sel,
                                             input logic [4:0] waddr, input logic [31:0] result,
                                             input logic [3:0] ld_type, input logic [31:0] hi,
                                             input logic [31:0] lo);
        return {pc, en, 4'h0, sel, 1'b1, waddr, result, 1'b1, 1'b0, hi, lo, ld_type};
    endfunction

    function automatic logic [135:0] make_wb(input logic [31:0] pc, input logic we, input logic [4:0] waddr,
                                             input logic [31:0] wdata, input logic [31:0] hi,
                                             input logic [31:0] lo);
        return {pc, we, waddr, wdata, 1'b1, 1'b0, hi, lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [145:0] bus, input logic [5:0] st);
        ex_to_mem_bus = bus;
        stall         = st;
    endtask

    task automatic checkReq(input string name, input logic exp_req);
        checks++;
        if (stallreq_for_mem !== exp_req) begin
            errors++;
            $display("[TB] FAIL %s stallreq got=%b exp=%b", name, stallreq_for_mem, exp_req);
        end
    endtask

    task automatic checkOutput(input string name, input logic [135:0] exp_bus, input logic exp_req);
        checks++;
        if (mem_to_wb_bus !== exp_bus) begin
            errors++;
            $display("[TB] FAIL %s wb_bus got=%h exp=%h", name, mem_to_wb_bus, exp_bus);
        end
        checks++;
        if (mem_to_id_bus !== exp_bus) begin
            errors++;
            $display("[TB] FAIL %s id_bus got=%h exp=%h", name, mem_to_id_bus, exp_bus);
        end
        checkReq(name, exp_req);
    endtask

`ifdef MEM_ALIGN_CHECK_EN
    task automatic checkAdel(input string name, input logic exp_adel);
        checks++;
        if (mem_adel !== exp_adel) begin
            errors++;
            $display("[TB] FAIL %s mem_adel got=%b exp=%b", name, mem_adel, exp_adel);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [31:0] pc, hi, lo;
        logic [4:0]  wa;

        rst = 1'b1;
        data_sram_rdata   = 32'h0;
        data_sram_data_ok = 1'b0;
        applyStimulus('0, ST_NONE);
        tick();
        tick();
        checkOutput("in_reset", '0, 1'b0);
        rst = 1'b0;
        tick();
        checkOutput("post_reset", '0, 1'b0);

        vecs.push_back('{LW,  1'b1, 1'b1, 32'h100, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0});
        vecs.push_back('{LB,  1'b1, 1'b1, 32'h103, 32'h80FF0000, 1'b1, 32'hFFFFFF80, 1'b0});
        vecs.push_back('{LBU, 1'b1, 1'b1, 32'h103, 32'h80FF0000, 1'b1, 32'h00000080, 1'b0});
        vecs.push_back('{LH,  1'b1, 1'b1, 32'h102, 32'h80FF0000, 1'b1, 32'hFFFF80FF, 1'b0});
        vecs.push_back('{LHU, 1'b1, 1'b1, 32'h102, 32'h80FF0000, 1'b1, 32'h000080FF, 1'b0});
        vecs.push_back('{LB,  1'b1, 1'b1, 32'h101, 32'h12345678, 1'b1, 32'h00000056, 1'b0});
        vecs.push_back('{LB,  1'b1, 1'b1, 32'h100, 32'h000000F0, 1'b1, 32'hFFFFFFF0, 1'b0});
        vecs.push_back('{LH,  1'b1, 1'b1, 32'h100, 32'h1234F00D, 1'b1, 32'hFFFFF00D, 1'b0});
        vecs.push_back('{LBU, 1'b1, 1'b1, 32'h102, 32'h00AB0000, 1'b1, 32'h000000AB, 1'b0});
        vecs.push_back('{LHU, 1'b1, 1'b1, 32'h100, 32'hABCD8001, 1'b1, 32'h00008001, 1'b0});
`ifndef MEM_ALIGN_CHECK_EN
        vecs.push_back('{LW,  1'b1, 1'b1, 32'h102, 32'h11223344, 1'b1, 32'h11223344, 1'b0});
`endif
        vecs.push_back('{SW,  1'b1, 1'b0, 32'h200, 32'h0,        1'b0, 32'h00000200, 1'b0});
        vecs.push_back('{LW,  1'b0, 1'b0, 32'h5555AAAA, 32'hFFFFFFFF, 1'b1, 32'h5555AAAA, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            pc = 32'hBFC00000 + 32'(4 * i);
            hi = 32'h11110000 + 32'(i);
            lo = 32'h22220000 + 32'(i);
            wa = 5'(i + 1);
            applyStimulus(make_ex(pc, vecs[i].en, vecs[i].sel, wa, vecs[i].addr, vecs[i].ld_type, hi, lo),
                          ST_NONE);
            tick();
            data_sram_data_ok = vecs[i].ok;
            data_sram_rdata   = vecs[i].rdata;
            #1;
            checkOutput($sformatf("vec%0d", i), make_wb(pc, 1'b1, wa, vecs[i].exp_wdata, hi, lo),
                        vecs[i].exp_req);
        end

        pc = 32'h80000000; hi = 32'hA0A0A0A0; lo = 32'hB0B0B0B0; wa = 5'd9;
        applyStimulus(make_ex(pc, 1'b1, 1'b1, wa, 32'h104, LW, hi, lo), ST_NONE);
        tick();
        data_sram_data_ok = 1'b0;
        stall = ST_HOLD;
        #1;
        checkReq("wait_c1", 1'b1);
        tick();
        checkReq("wait_c2", 1'b1);
        tick();
        checkReq("wait_c3", 1'b1);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0F0E0D0C;
        applyStimulus('0, ST_NONE);
        #1;
        checkOutput("wait_done", make_wb(pc, 1'b1, wa, 32'h0F0E0D0C, hi, lo), 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        checkOutput("wait_idle", '0, 1'b0);

        pc = 32'h80000010; hi = 32'hC0C0C0C0; lo = 32'hD0D0D0D0; wa = 5'd12;
        applyStimulus(make_ex(pc, 1'b1, 1'b1, wa, 32'h10A, LH, hi, lo), ST_NONE);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFEF00D;
        stall = ST_HOLD;
        #1;
        checkOutput("hold0", make_wb(pc, 1'b1, wa, 32'hFFFFCAFE, hi, lo), 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0BADBAD0;
        #1;
        checkOutput("hold1", make_wb(pc, 1'b1, wa, 32'hFFFFCAFE, hi, lo), 1'b0);
        tick();
        checkOutput("hold2", make_wb(pc, 1'b1, wa, 32'hFFFFCAFE, hi, lo), 1'b0);
        applyStimulus('0, ST_NONE);
        tick();
        checkOutput("hold_release", '0, 1'b0);

        pc = 32'h80000020; hi = 32'h12121212; lo = 32'h34343434; wa = 5'd3;
        applyStimulus(make_ex(pc, 1'b0, 1'b0, wa, 32'h1234ABCD, LW, hi, lo), ST_NONE);
        tick();
        checkOutput("alu", make_wb(pc, 1'b1, wa, 32'h1234ABCD, hi, lo), 1'b0);
        stall = ST_BUBBLE;
        tick();
        checkOutput("bubble", '0, 1'b0);

        applyStimulus(make_ex(32'h80000030, 1'b1, 1'b1, 5'd4, 32'h10C, LW, hi, lo), ST_NONE);
        tick();
        stall = ST_HOLD;
        #1;
        checkReq("flush_c1", 1'b1);
        tick();
        stall = ST_BUBBLE;
        #1;
        checkReq("flush_c2", 1'b1);
        tick();
        applyStimulus('0, ST_NONE);
        #1;
        checkOutput("flush_wait", '0, 1'b0);

        applyStimulus(make_ex(32'h80000040, 1'b1, 1'b1, 5'd5, 32'h110, LW, hi, lo), ST_NONE);
        tick();
        stall = ST_HOLD;
        tick();
        checkReq("rst_pre", 1'b1);
        rst = 1'b1;
        #1;
        checkReq("rst_comb", 1'b0);
        tick();
        checkOutput("rst_wait", '0, 1'b0);
        rst = 1'b0;
        applyStimulus('0, ST_NONE);
        tick();
        checkOutput("rst_after", '0, 1'b0);

        pc = 32'h80000050; wa = 5'd6;
        applyStimulus(make_ex(pc, 1'b1, 1'b1, wa, 32'h114, LW, hi, lo), ST_NONE);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h76543210;
        applyStimulus('0, ST_NONE);
        #1;
        checkOutput("post_rst_lw", make_wb(pc, 1'b1, wa, 32'h76543210, hi, lo), 1'b0);
        tick();
        data_sram_data_ok = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        pc = 32'h80000060; wa = 5'd7;
        applyStimulus(make_ex(pc, 1'b1, 1'b1, wa, 32'h102, LW, hi, lo), ST_NONE);
        tick();
        checkAdel("adel_lw", 1'b1);
        checkReq("adel_lw", 1'b0);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h11223344;
        #1;
        checkOutput("adel_lw_bus", make_wb(pc, 1'b0, wa, 32'h11223344, hi, lo), 1'b0);
        data_sram_data_ok = 1'b0;
        applyStimulus(make_ex(pc, 1'b1, 1'b1, wa, 32'h101, LH, hi, lo), ST_NONE);
        tick();
        checkAdel("adel_lh", 1'b1);
        checkReq("adel_lh", 1'b0);
        applyStimulus(make_ex(pc, 1'b1, 1'b1, wa, 32'h100, LHU, hi, lo), ST_NONE);
        tick();
        checkAdel("adel_lhu_ok", 1'b0);
        checkReq("adel_lhu_ok", 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000BEEF;
        applyStimulus('0, ST_NONE);
        #1;
        checkOutput("adel_lhu_bus", make_wb(pc, 1'b1, wa, 32'h0000BEEF, hi, lo), 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
